// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: RV32 opcode values, instruction field
// positions, register-file size and the writeback-stage state encoding.
// Used by both the execute and writeback stages.
package pipeline_pkg;

    localparam int REGISTER_COUNT       = 32;
    localparam int REGISTER_INDEX_WIDTH = $clog2(REGISTER_COUNT);

    // Instruction field slices
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;

    // Major opcodes
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_OP     = 7'b0110011;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_LOAD   = 7'b0000011;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_BRANCH = 7'b1100011;
    localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'b00,
        WB_COMMIT = 2'b01,
        WB_FAULT  = 2'b10
    } wbState_t;

    // True for opcodes whose result lands in rd; unknown opcodes retire as no-ops.
    function automatic logic writesRegister(input logic [OPCODE_MSB:OPCODE_LSB] opcode);
        logic result;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR,
            OPCODE_OP_IMM, OPCODE_OP, OPCODE_LOAD: result = 1'b1;
            OPCODE_BRANCH, OPCODE_STORE:           result = 1'b0;
            default:                               result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running enable counter counting retired instructions; wraps at 2^WIDTH.
// Only built when WRITEBACK_RETIRE_COUNT_EN is defined.
`ifdef WRITEBACK_RETIRE_COUNT_EN
module retire_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clockIn,
    input  logic             resetIn,
    input  logic             enableIn,
    output logic [WIDTH-1:0] countOut
);

    localparam logic [WIDTH-1:0] COUNT_STEP = WIDTH'(1);

    // Count one per enabled cycle, natural wrap on overflow.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            countOut <= '0;
        end else if (enableIn) begin
            countOut <= countOut + COUNT_STEP;
        end else begin
            countOut <= countOut;
        end
    end

endmodule
`endif

// File: rtl/writeback_stage.sv
// Writeback stage: captures one retired instruction per cycle from the
// execute stage, then commits it on the following cycle (register write,
// next-PC publish, fetch redirect). A redirect to a misaligned target
// latches a sticky fault and the stage stops until reset.
// Optional feature macro: WRITEBACK_RETIRE_COUNT_EN adds retiredCountOut.
module writeback_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
    input  logic                            clockIn,
    input  logic                            resetIn,
    input  logic                            startIn,
    input  logic [31:0]                     instructionIn,
    input  logic [31:0]                     addressIn,
    input  logic [1:0][31:0]                resultsIn,
    output logic                            registerWriteEnableOut,
    output logic [REGISTER_INDEX_WIDTH-1:0] registerIndexOut,
    output logic [31:0]                     registerValueOut,
    output logic [31:0]                     programCounterOut,
    output logic                            programCounterValidOut,
    output logic                            redirectOut,
    output logic                            readyOut,
    output logic                            faultOut
`ifdef WRITEBACK_RETIRE_COUNT_EN
    ,
    output logic [63:0]                     retiredCountOut
`endif
);

    wbState_t                        state_r;
    logic [OPCODE_MSB:OPCODE_LSB]    opcode_r;
    logic [REGISTER_INDEX_WIDTH-1:0] rd_r;
    logic [31:0]                     address_r;
    logic [31:0]                     value_r;
    logic [31:0]                     target_r;

    logic        writesRd_s;
    logic        redirect_s;
    logic        fault_s;
    logic [31:0] nextPc_s;
    logic        unusedInstrBits_s;

    // Only opcode and rd matter at writeback; the rest of the word is dropped.
    assign unusedInstrBits_s = ^instructionIn[31:RD_MSB+1];

    // Decode the captured instruction into its commit effects.
    always_comb begin
        writesRd_s = writesRegister(opcode_r);
        redirect_s = (opcode_r == OPCODE_JAL) || (opcode_r == OPCODE_JALR) ||
                     ((opcode_r == OPCODE_BRANCH) && value_r[0]);
        if (redirect_s) begin
            nextPc_s = target_r;
        end else begin
            nextPc_s = address_r + 32'd4;
        end
        fault_s = redirect_s && (target_r[1:0] != 2'b00);
    end

    // Writeback FSM: capture, commit with registered strobes, sticky fault.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state_r                <= WB_IDLE;
            opcode_r               <= '0;
            rd_r                   <= '0;
            address_r              <= 32'h0000_0000;
            value_r                <= 32'h0000_0000;
            target_r               <= 32'h0000_0000;
            registerWriteEnableOut <= 1'b0;
            registerIndexOut       <= '0;
            registerValueOut       <= 32'h0000_0000;
            programCounterOut      <= RESET_ADDRESS;
            programCounterValidOut <= 1'b0;
            redirectOut            <= 1'b0;
            readyOut               <= 1'b0;
            faultOut               <= 1'b0;
        end else begin
            registerWriteEnableOut <= 1'b0;
            programCounterValidOut <= 1'b0;
            redirectOut            <= 1'b0;
            readyOut               <= 1'b0;
            case (state_r)
                WB_IDLE: begin
                    if (startIn) begin
                        opcode_r  <= instructionIn[OPCODE_MSB:OPCODE_LSB];
                        rd_r      <= instructionIn[RD_MSB:RD_LSB];
                        address_r <= addressIn;
                        value_r   <= resultsIn[0];
                        target_r  <= resultsIn[1];
                        state_r   <= WB_COMMIT;
                    end else begin
                        state_r   <= WB_IDLE;
                    end
                end
                WB_COMMIT: begin
                    if (fault_s) begin
                        // Fault wins over a simultaneous new instruction.
                        faultOut <= 1'b1;
                        state_r  <= WB_FAULT;
                    end else begin
                        registerWriteEnableOut <= writesRd_s && (rd_r != '0);
                        registerIndexOut       <= rd_r;
                        registerValueOut       <= value_r;
                        programCounterOut      <= nextPc_s;
                        programCounterValidOut <= 1'b1;
                        redirectOut            <= redirect_s;
                        readyOut               <= 1'b1;
                        if (startIn) begin
                            opcode_r  <= instructionIn[OPCODE_MSB:OPCODE_LSB];
                            rd_r      <= instructionIn[RD_MSB:RD_LSB];
                            address_r <= addressIn;
                            value_r   <= resultsIn[0];
                            target_r  <= resultsIn[1];
                            state_r   <= WB_COMMIT;
                        end else begin
                            state_r   <= WB_IDLE;
                        end
                    end
                end
                WB_FAULT: begin
                    state_r <= WB_FAULT;
                end
                default: begin
                    state_r <= WB_IDLE;
                end
            endcase
        end
    end

`ifdef WRITEBACK_RETIRE_COUNT_EN
    retire_counter #(
        .WIDTH(64)
    ) retireCounter (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .enableIn(readyOut),
        .countOut(retiredCountOut)
    );
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage: accepts one completed instruction per cycle from the execute stage's result handshake and commits it. It writes the destination register, publishes the architectural program counter, and latches a sticky fault on a misaligned control-flow target. It sits between the execute stage outputs and the register file / fetch-redirect logic.

## Interface
- RESET_ADDRESS, 32'h0000_0000, value of programCounterOut after reset
- clockIn  input  1  single clock, rising edge
- resetIn  input  1  asynchronous, active-low reset
- startIn  input  1  execute stage's readyOut; one instruction offered on each cycle it is high
- instructionIn  input  32  RV32 instruction word being retired
- addressIn  input  32  address of that instruction
- resultsIn  input  32 x2  [0] = rd value or branch-taken flag (bit 0); [1] = control-flow target
- registerWriteEnableOut  output  1  one-cycle register-file write strobe
- registerIndexOut  output  5  destination register, instructionIn[11:7]
- registerValueOut  output  32  value written
- programCounterOut  output  32  next architectural PC
- programCounterValidOut  output  1  one-cycle strobe: programCounterOut updated
- redirectOut  output  1  one-cycle strobe: PC is non-sequential (fetch must flush)
- readyOut  output  1  one-cycle strobe: instruction committed
- faultOut  output  1  sticky misaligned-target fault

## Operation
- FSM states: IDLE, COMMIT, FAULT.
- IDLE: startIn=1 -> capture instructionIn, addressIn, resultsIn -> COMMIT.
- COMMIT: outputs are driven from captured values for one cycle. startIn=1 in the same cycle captures the next instruction and stays in COMMIT (back-to-back, 1/cycle). startIn=0 -> IDLE.
- Opcode = instruction[6:0]. Writes rd: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011, LOAD 0000011. No write: BRANCH 1100011, STORE 0100011. Any other opcode is committed as a no-op: readyOut and PC advance only.
- registerWriteEnableOut = writes-rd && rd != 0. registerValueOut = results[0].
- Redirect: JAL and JALR always; BRANCH when results[0][0]=1. Redirect sets next PC = results[1] and pulses redirectOut. Otherwise next PC = address + 4, with 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
- Fault: redirect target[1:0] != 0. The instruction is not committed: no register write, no PC strobe, no readyOut. faultOut=1, state goes to FAULT. FAULT ignores startIn until reset.

## Timing
- Latency: startIn high at edge N -> commit strobes high for the cycle after edge N+1. Throughput is 1 instruction/cycle.
- All strobes are single-cycle and are low in IDLE and FAULT.
- Reset (async assert, any state including mid-COMMIT): all strobes 0, registerIndexOut 0, registerValueOut 0, programCounterOut = RESET_ADDRESS, faultOut 0, state IDLE. The in-flight instruction is dropped.
- A fault in COMMIT takes priority over a simultaneous startIn. The new instruction is discarded.

## Configuration
- WRITEBACK_RETIRE_COUNT_EN defined: adds retiredCountOut (output, 64 bits). It increments by 1 in every cycle readyOut=1, resets to 0, wraps at 2^64, and holds in FAULT.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package pipeline_pkg holds:
  - opcode localparams
  - the writeback state enum
  - REGISTER_COUNT=32
  - the instruction field slice constants (rd 11:7, opcode 6:0)
- The same package is used by the execute stage.
- Optional sub-module retire_counter (64-bit enable counter) is instantiated only under the macro.

## Test plan
- OP instruction 32'h002081B3 (add x3), address 32'h100, results[0]=32'h5, one startIn pulse:
  - next cycle: write x3=5, programCounterOut=32'h104, readyOut=1, redirectOut=0.
- BRANCH with results[0]=1, results[1]=32'h200:
  - no register write; programCounterOut=32'h200, redirectOut=1.
  - Repeat with results[0]=0: programCounterOut=address+4, redirectOut=0.
- JAL rd=x0, target 32'h80, link 32'h44:
  - registerWriteEnableOut=0; PC=32'h80, redirectOut=1.
- Four back-to-back startIn cycles, mixed OP/STORE:
  - four consecutive readyOut cycles; writes only for the OP instructions.
  - Under the macro: retiredCountOut=4.
- JALR with target 32'h102:
  - faultOut=1, no readyOut; later startIn pulses are ignored.
  - resetIn low mid-sequence: PC=RESET_ADDRESS, faultOut=0.
- address 32'hFFFF_FFFC, OP instruction:
  - programCounterOut=32'h0000_0000.
